// File: rtl/fp_issue_ctrl.sv
// Single-outstanding FP issue controller: accepts one decoded FP op, runs the FPU
// handshakes, writes back the result one cycle after it arrives, and aborts on flush or watchdog.
module fp_issue_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        dec_valid_i,
   input  logic [4:0]  dec_rd_i,
   input  logic        dec_regwrite_i,
   output logic        dec_ready_o,
   output logic        stall_o,
   output logic        fpu_in_valid_o,
   input  logic        fpu_in_ready_i,
   input  logic        fpu_out_valid_i,
   output logic        fpu_out_ready_o,
   input  logic [31:0] fpu_result_i,
   input  logic [4:0]  fpu_status_i,
   input  logic        flush_i,
   output logic        fpu_flush_o,
   output logic        wb_we_o,
   output logic [4:0]  wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic [4:0]  fflags_o,
   input  logic        fflags_clr_i,
   output logic        busy_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;

   localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic        rw_q, rw_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  st_q, st_d;
   logic [4:0]  fflags_q, fflags_d;
   logic        flush_act;
   logic        to_act;
   logic        run;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      rw_d      = rw_q;
      res_d     = res_q;
      st_d      = st_q;
      flush_act = 1'b0;
      to_act    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dec_valid_i && !flush_i) begin
               rd_d    = dec_rd_i;
               rw_d    = dec_regwrite_i;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (flush_i) begin
               flush_act = 1'b1;
               state_d   = S_IDLE;
            end else if (fpu_in_ready_i) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // flush beats a same-cycle result, and a result beats the watchdog
            if (flush_i) begin
               flush_act = 1'b1;
               state_d   = S_IDLE;
            end else if (fpu_out_valid_i) begin
               res_d   = fpu_result_i;
               st_d    = fpu_status_i;
               state_d = S_WB;
            end else if (cnt_q == CNT_LAST) begin
               to_act  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      fflags_d = (fflags_clr_i ? 5'd0 : fflags_q) | ((state_q == S_WB) ? st_q : 5'd0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rd_q     <= '0;
         rw_q     <= 1'b0;
         res_q    <= '0;
         st_q     <= '0;
         fflags_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         rw_q     <= rw_d;
         res_q    <= res_d;
         st_q     <= st_d;
         fflags_q <= fflags_d;
      end
   end

   // every output is forced low while reset is held, including the first reset cycle
   assign run             = !rst_i;
   assign dec_ready_o     = run && (state_q == S_IDLE) && !flush_i;
   assign stall_o         = run && dec_valid_i && !dec_ready_o;
   assign busy_o          = run && (state_q != S_IDLE);
   assign fpu_in_valid_o  = run && (state_q == S_ISSUE);
   assign fpu_out_ready_o = run && (state_q == S_WAIT);
   assign fpu_flush_o     = run && (flush_act || to_act);
   assign timeout_o       = run && to_act;
   assign wb_we_o         = run && (state_q == S_WB) && rw_q;
   assign wb_addr_o       = wb_we_o ? rd_q : 5'd0;
   assign wb_data_o       = wb_we_o ? res_q : 32'd0;
   assign fflags_o        = run ? fflags_q : 5'd0;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: randomized operations with a transaction-level model
// feeding an event scoreboard (writeback / timeout / flush) checked by a monitor.
module tb_fp_issue_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        dec_valid_i = 1'b0;
   logic [4:0]  dec_rd_i = '0;
   logic        dec_regwrite_i = 1'b0;
   logic        dec_ready_o;
   logic        stall_o;
   logic        fpu_in_valid_o;
   logic        fpu_in_ready_i = 1'b0;
   logic        fpu_out_valid_i = 1'b0;
   logic        fpu_out_ready_o;
   logic [31:0] fpu_result_i = '0;
   logic [4:0]  fpu_status_i = '0;
   logic        flush_i = 1'b0;
   logic        fpu_flush_o;
   logic        wb_we_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;
   logic [4:0]  fflags_o;
   logic        fflags_clr_i = 1'b0;
   logic        busy_o;
   logic        timeout_o;

   fp_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dec_valid_i(dec_valid_i), .dec_rd_i(dec_rd_i), .dec_regwrite_i(dec_regwrite_i),
      .dec_ready_o(dec_ready_o), .stall_o(stall_o),
      .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
      .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
      .flush_i(flush_i), .fpu_flush_o(fpu_flush_o),
      .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
      .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   localparam int EV_WB = 0, EV_TO = 1, EV_FL = 2;
   localparam int SC_OK = 0, SC_FL_ISSUE = 1, SC_FL_WAIT = 2, SC_FL_OUT = 3, SC_TO = 4, SC_LAST = 5;

   typedef struct {
      int          kind;
      logic [4:0]  addr;
      logic [31:0] data;
   } ev_t;

   ev_t        sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [4:0] fflags_m = '0;
   logic       offered_g = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [4:0] addr, input logic [31:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: any writeback, timeout or flush pulse must match the next expected event.
   ev_t mon_e;
   int  mon_k;
   always @(negedge clk_i) begin
      if (!wb_we_o) begin
         chk("wb_addr_idle", 32'(wb_addr_o), 32'd0);
         chk("wb_data_idle", wb_data_o, 32'd0);
      end
      if (wb_we_o || timeout_o || fpu_flush_o) begin
         mon_k = wb_we_o ? EV_WB : (timeout_o ? EV_TO : EV_FL);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual_kind=%0d expected=none", mon_k);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_kind", 32'(mon_k), 32'(mon_e.kind));
            if (mon_e.kind == EV_WB) begin
               chk("sb_addr", 32'(wb_addr_o), 32'(mon_e.addr));
               chk("sb_data", wb_data_o, mon_e.data);
            end
            if (mon_e.kind == EV_TO) chk("sb_to_flush", 32'(fpu_flush_o), 32'd1);
         end
      end
   end

   task automatic busy_chk(input logic hold);
      chk("busy", 32'(busy_o), 32'd1);
      if (hold) begin
         chk("hold_stall", 32'(stall_o), 32'd1);
         chk("hold_not_ready", 32'(dec_ready_o), 32'd0);
      end
   endtask

   task automatic rst_outs_chk();
      chk("rst_dec_ready", 32'(dec_ready_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_in_valid", 32'(fpu_in_valid_o), 32'd0);
      chk("rst_out_ready", 32'(fpu_out_ready_o), 32'd0);
      chk("rst_flush", 32'(fpu_flush_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_we", 32'(wb_we_o), 32'd0);
      chk("rst_fflags", 32'(fflags_o), 32'd0);
   endtask

   // One complete operation from offer to return-to-idle, with the chosen fate.
   task automatic run_op(input logic [4:0] rd, input logic rw, input int sc,
                         input int in_dly, input int out_dly, input logic clr_wb,
                         input logic wb_fl, input logic idle_fl, input logic hold,
                         input logic [31:0] res, input logic [4:0] st);
      int n;
      if (!offered_g) step();
      dec_valid_i    = 1'b1;
      dec_rd_i       = rd;
      dec_regwrite_i = rw;
      if (!offered_g) begin
         if (idle_fl) begin
            flush_i = 1'b1;
            @(negedge clk_i);
            chk("idle_flush_ready", 32'(dec_ready_o), 32'd0);
            chk("idle_flush_stall", 32'(stall_o), 32'd1);
            step();
            flush_i = 1'b0;
         end
         @(negedge clk_i);
         chk("idle_ready", 32'(dec_ready_o), 32'd1);
         chk("idle_busy", 32'(busy_o), 32'd0);
      end
      step();
      if (hold) begin
         dec_rd_i = rd + 5'd1;
      end else begin
         dec_valid_i    = 1'b0;
         dec_rd_i       = 5'($urandom);
         dec_regwrite_i = 1'($urandom);
      end
      for (int i = 0; i < in_dly; i++) begin
         @(negedge clk_i);
         busy_chk(hold);
         chk("in_valid_held", 32'(fpu_in_valid_o), 32'd1);
         step();
      end
      if (sc == SC_FL_ISSUE) begin
         flush_i = 1'b1;
         push(EV_FL, '0, '0);
         @(negedge clk_i);
         busy_chk(hold);
         step();
         flush_i = 1'b0;
      end else begin
         fpu_in_ready_i = 1'b1;
         @(negedge clk_i);
         busy_chk(hold);
         chk("in_valid", 32'(fpu_in_valid_o), 32'd1);
         step();
         fpu_in_ready_i = 1'b0;
         n = (sc == SC_TO) ? 4 : ((sc == SC_LAST) ? 3 : out_dly);
         for (int i = 0; i < n; i++) begin
            if (sc == SC_TO && i == n - 1) push(EV_TO, '0, '0);
            @(negedge clk_i);
            busy_chk(hold);
            chk("out_ready", 32'(fpu_out_ready_o), 32'd1);
            chk("in_valid_wait", 32'(fpu_in_valid_o), 32'd0);
            step();
         end
         if (sc == SC_FL_WAIT || sc == SC_FL_OUT) begin
            flush_i         = 1'b1;
            fpu_out_valid_i = (sc == SC_FL_OUT);
            fpu_result_i    = res;
            fpu_status_i    = st;
            push(EV_FL, '0, '0);
            @(negedge clk_i);
            busy_chk(hold);
            step();
            flush_i         = 1'b0;
            fpu_out_valid_i = 1'b0;
         end else if (sc != SC_TO) begin
            fpu_out_valid_i = 1'b1;
            fpu_result_i    = res;
            fpu_status_i    = st;
            if (rw) push(EV_WB, rd, res);
            @(negedge clk_i);
            busy_chk(hold);
            step();
            fpu_out_valid_i = 1'b0;
            fpu_result_i    = $urandom;
            fpu_status_i    = 5'($urandom);
            fflags_clr_i    = clr_wb;
            flush_i         = wb_fl;
            @(negedge clk_i);
            busy_chk(hold);
            chk("wb_we_latency", 32'(wb_we_o), 32'(rw));
            fflags_m = (clr_wb ? 5'd0 : fflags_m) | st;
            step();
            fflags_clr_i = 1'b0;
            flush_i      = 1'b0;
         end
      end
      @(negedge clk_i);
      chk("end_busy", 32'(busy_o), 32'd0);
      chk("fflags", 32'(fflags_o), 32'(fflags_m));
      if (hold) chk("hold_first_idle_ready", 32'(dec_ready_o), 32'd1);
      offered_g = hold;
   endtask

   task automatic idle_clr();
      step();
      fflags_clr_i = 1'b1;
      step();
      fflags_clr_i = 1'b0;
      fflags_m     = '0;
      @(negedge clk_i);
      chk("fflags_clear", 32'(fflags_o), 32'd0);
   endtask

   task automatic reset_mid();
      step();
      dec_valid_i    = 1'b1;
      dec_rd_i       = 5'd7;
      dec_regwrite_i = 1'b1;
      step();
      dec_valid_i    = 1'b0;
      fpu_in_ready_i = 1'b1;
      step();
      fpu_in_ready_i  = 1'b0;
      rst_i           = 1'b1;
      fpu_out_valid_i = 1'b1;
      fpu_result_i    = 32'hDEAD_BEEF;
      fpu_status_i    = 5'h1F;
      dec_valid_i     = 1'b1;
      @(negedge clk_i);
      rst_outs_chk();
      step();
      rst_i       = 1'b0;
      dec_valid_i = 1'b0;
      fflags_m    = '0;
      @(negedge clk_i);
      chk("post_rst_out_ready", 32'(fpu_out_ready_o), 32'd0);
      chk("post_rst_busy", 32'(busy_o), 32'd0);
      chk("post_rst_fflags", 32'(fflags_o), 32'd0);
      step();
      fpu_out_valid_i = 1'b0;
   endtask

   initial begin
      logic [4:0] rd;
      logic       hold;
      int         r, sc;

      dec_valid_i = 1'b1;
      @(negedge clk_i);
      rst_outs_chk();
      step();
      @(negedge clk_i);
      rst_outs_chk();
      step();
      rst_i       = 1'b0;
      dec_valid_i = 1'b0;

      // basic op, minimum latency
      run_op(5'd5, 1'b1, SC_OK, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 5'h01);
      chk("basic_fflags", 32'(fflags_o), 32'h01);
      // held offer while busy, then back-to-back acceptance
      run_op(5'd9, 1'b1, SC_OK, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 5'h02);
      run_op(5'd10, 1'b1, SC_OK, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D, 5'h00);
      run_op(5'd3, 1'b1, SC_TO, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h08);
      run_op(5'd4, 1'b1, SC_FL_OUT, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 5'h10);
      idle_clr();
      run_op(5'd6, 1'b1, SC_OK, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 5'h10);
      run_op(5'd7, 1'b1, SC_OK, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 5'h04);
      chk("clr_accrue_fflags", 32'(fflags_o), 32'h04);
      run_op(5'd8, 1'b1, SC_LAST, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7F80_0000, 5'h04);
      run_op(5'd11, 1'b0, SC_OK, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA, 5'h01);
      run_op(5'd12, 1'b1, SC_FL_ISSUE, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h02);
      run_op(5'd13, 1'b1, SC_FL_WAIT, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h02);
      reset_mid();

      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 9);
         sc = (r <= 4) ? SC_OK : r - 4;
         rd = 5'($urandom);
         hold = (k != 199) && ($urandom_range(0, 4) == 0);
         if (!offered_g && $urandom_range(0, 7) == 0) idle_clr();
         run_op(rd, $urandom_range(0, 3) != 0, sc, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                hold, $urandom, 5'($urandom));
      end

      step();
      step();
      @(negedge clk_i);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
